mips_memory2: RTL and testbench
===============================

// Module: mips_memory2
// PURPOSE
//  Word-organised, big-endian instruction/data memory for the MIPS core and its loader.
//  Supports single-word and 4/8/16-word burst reads and writes from one start address,
//  one beat per clock. busy tells the master when the block can accept a new request.
//  The loader writes the program image, then the core or bench reads it back.
// PARAMETERS
//  BASE_ADDR  32'h8002_0000  byte address of memory word 0
//  MEM_WORDS  16384          depth in 32-bit words; mapped range is [BASE_ADDR, BASE_ADDR+4*MEM_WORDS)
// PORTS
//  clk          in   1   clock; all state changes on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  addr         in   32  byte start address of the request; bits [1:0] ignored
//  din          in   32  write data, one word per beat; big-endian (din[31:24] = lowest byte address)
//  dout         out  32  read data, registered, same byte order as din
//  access_size  in   2   burst length: 00=1, 01=4, 10=8, 11=16 words
//  rw           in   1   1 = write, 0 = read
//  enable       in   1   request strobe; sampled only when idle
//  busy         out  1   1 = burst in progress, new request not accepted
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE, busy=0, dout=0, beat counter=0. Memory array is
//    not cleared. Reset mid-burst aborts the burst; the remaining beats are dropped.
//  - States:
//    - IDLE: busy=0.
//      On a rising edge with enable=1 the request is accepted (beat 0 executes at this edge):
//      - capture word address A=addr[31:2], rw, and N = burst length.
//      - write: mem[A] <= din.
//      - read: dout <= mem[A].
//      - if N>1, go to BURST with beats-remaining = N-1 and busy <= 1.
//    - BURST: each rising edge executes beat i (i = 1..N-1) at word address A+i.
//      - write: mem[A+i] <= din. din is sampled at that edge.
//      - read: dout <= mem[A+i].
//      - on the edge that executes beat N-1, busy <= 0 and the state returns to IDLE.
//  - Timing: busy is high for exactly N-1 cycles after acceptance; it is never set for N=1.
//    The next request can be accepted on the first edge where busy=0 is registered,
//    so back-to-back bursts have no idle cycle.
//  - During BURST, enable, addr, rw and access_size are ignored; the burst always completes.
//  - Read latency: word i appears on dout after the edge executing beat i. dout holds its
//    last value while IDLE.
//  - Address map: word index = A+i - BASE_ADDR[31:2]. No wrap-around at burst or array end.
//    - beats outside the mapped range: writes are dropped, reads return 32'h0.
//  - Byte order: mem byte address a+0 maps to data bits [31:24], a+3 maps to bits [7:0].
// TESTING
//  1. Reset: hold rst_n=0 mid-burst -> busy=0 and dout=0 immediately. After release, a
//     single read is accepted on the first enable.
//  2. Single write then read: write 32'hDEAD_BEEF to 0x8002_0010 (size 00) -> busy stays 0.
//     A read from the same address gives dout=32'hDEAD_BEEF on the next edge.
//  3. 16-beat write burst: size 11, rw=1, addr 0x8002_0000, din=k on beat k ->
//     - busy is high for 15 cycles.
//     - a second burst at 0x8002_0040 is accepted on the very next edge.
//     - read-back of all 32 words matches.
//  4. Burst read: size 10 from 0x8002_0000 after test 3 -> dout = 0..7 on 8 consecutive
//     edges, busy high for 7 cycles. enable toggling mid-burst has no effect.
//  5. Out-of-range access: write to 0x8001_FFFC, then read it -> dout=0; memory is unchanged.
//  6. Sizes 01 and 10: busy high for 3 and 7 cycles respectively; the address advances by 4
//     per beat.

Source files
------------

// File: rtl/mips_memory2.sv
// -----------------------------------------------------------------------------
// mips_memory2
//   Word-organised, big-endian instruction/data memory shared by the MIPS core
//   and its program loader. A request starts a single-word or 4/8/16-word
//   burst at one start address. The burst then runs one beat per clock at
//   consecutive word addresses.
//
// Ports
//   clk          in   1   clock, all state changes on the rising edge
//   rst_n        in   1   asynchronous active-low reset (aborts any burst)
//   addr         in   32  byte start address, bits [1:0] ignored
//   din          in   32  write data, one word per beat (din[31:24] = byte a+0)
//   dout         out  32  registered read data, same byte order as din
//   access_size  in   2   burst length: 00=1, 01=4, 10=8, 11=16 words
//   rw           in   1   1 = write, 0 = read
//   enable       in   1   request strobe, sampled only while idle
//   busy         out  1   burst in progress, new requests are not accepted
// -----------------------------------------------------------------------------
module mips_memory2 #(
    parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
    parameter int          MEM_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [1:0]  access_size,
    input  logic        rw,
    input  logic        enable,
    output logic        busy
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
    localparam logic [29:0] DEPTH     = 30'(MEM_WORDS);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t      state_q,  state_d;
    logic [29:0] waddr_q,  waddr_d;   // word address of the next burst beat
    logic        rw_q,     rw_d;
    logic [3:0]  remain_q, remain_d;  // beats still to execute after this one
    logic [31:0] dout_q,   dout_d;

    logic [31:0] mem [MEM_WORDS];

    logic          beat_go;
    logic [29:0]   beat_addr;
    logic          beat_rw;
    logic [29:0]   offset;
    logic          in_range;
    logic [AW-1:0] mem_idx;
    logic          mem_we;
    logic [3:0]    len_m1;

    // High address bits of the offset only matter for the range compare.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], offset[29:AW]};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a value
        // unassigned; otherwise synthesis infers a latch.
        state_d  = state_q;
        waddr_d  = waddr_q;
        rw_d     = rw_q;
        remain_d = remain_q;
        dout_d   = dout_q;

        unique case (access_size)
            2'b00:   len_m1 = 4'd0;
            2'b01:   len_m1 = 4'd3;
            2'b10:   len_m1 = 4'd7;
            default: len_m1 = 4'd15;
        endcase

        // In IDLE, beat 0 uses the live request. In BURST, the captured request is used.
        beat_go   = (state_q == BURST) || enable;
        beat_addr = (state_q == BURST) ? waddr_q : addr[31:2];
        beat_rw   = (state_q == BURST) ? rw_q    : rw;

        // Modular subtraction: addresses below the base wrap to a huge offset,
        // so a single unsigned compare covers both ends of the mapped window.
        offset   = beat_addr - BASE_WORD;
        in_range = (offset < DEPTH);
        mem_idx  = offset[AW-1:0];
        mem_we   = rst_n && beat_go && beat_rw && in_range;

        if (beat_go && !beat_rw) begin
            dout_d = in_range ? mem[mem_idx] : 32'h0;
        end

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    waddr_d  = beat_addr + 30'd1;
                    rw_d     = rw;
                    remain_d = len_m1;
                    if (len_m1 != 4'd0) begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                waddr_d  = waddr_q + 30'd1;
                remain_d = remain_q - 4'd1;
                if (remain_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            waddr_q  <= '0;
            rw_q     <= 1'b0;
            remain_q <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            waddr_q  <= waddr_d;
            rw_q     <= rw_d;
            remain_q <= remain_d;
            dout_q   <= dout_d;
        end
    end

    // NOTE: the storage array has no reset. Clearing it would force it into
    // flops instead of RAM, and the loader writes the image anyway.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= din;
        end
    end

    assign dout = dout_q;
    assign busy = (state_q == BURST);

endmodule

// File: tb/tb_mips_memory2.sv
// -----------------------------------------------------------------------------
// tb_mips_memory2
//   Directed testbench for mips_memory2. Inputs are driven and outputs are
//   sampled 1 ns after each rising edge. All expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_mips_memory2;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] vec [16];

    mips_memory2 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .access_size (access_size),
        .rw          (rw),
        .enable      (enable),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int burst_len(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    task automatic fill_seq(input logic [31:0] start);
        for (int i = 0; i < 16; i++) vec[i] = start + 32'(i);
    endtask

    task automatic single_write(input logic [31:0] a, input logic [31:0] d);
        enable = 1'b1; rw = 1'b1; addr = a; access_size = 2'b00; din = d;
        tick();
        enable = 1'b0; rw = 1'b0;
    endtask

    task automatic single_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        enable = 1'b1; rw = 1'b0; addr = a; access_size = 2'b00;
        tick();
        enable = 1'b0;
        check(tag, dout, exp);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Burst read compared against vec[]. With toggle set, the request inputs
    // change during the burst and must be ignored.
    task automatic burst_read(input string tag, input logic [31:0] a, input logic [1:0] sz,
                              input bit toggle);
        int n;
        int busy_cnt;
        n = burst_len(sz);
        busy_cnt = 0;
        enable = 1'b1; rw = 1'b0; addr = a; access_size = sz;
        tick();
        enable = 1'b0;
        check($sformatf("%s_beat0", tag), dout, vec[0]);
        for (int i = 1; i < n; i++) begin
            if (busy) busy_cnt++;
            if (toggle) begin
                enable = i[0]; addr = 32'h8002_0100; access_size = 2'b00; rw = i[0];
                din = 32'hFFFF_FFFF;
            end
            tick();
            check($sformatf("%s_beat%0d", tag, i), dout, vec[i]);
        end
        enable = 1'b0; rw = 1'b0;
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n - 1));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic burst_write(input string tag, input logic [31:0] a, input logic [1:0] sz);
        int n;
        int busy_cnt;
        n = burst_len(sz);
        busy_cnt = 0;
        enable = 1'b1; rw = 1'b1; addr = a; access_size = sz; din = vec[0];
        tick();
        enable = 1'b0;
        for (int i = 1; i < n; i++) begin
            if (busy) busy_cnt++;
            din = vec[i];
            tick();
        end
        rw = 1'b0;
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n - 1));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        rst_n = 1'b0; addr = '0; din = '0; access_size = 2'b00; rw = 1'b0; enable = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dout", dout, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single write then read back.
        single_write(32'h8002_0010, 32'hDEAD_BEEF);
        check("single_write_busy", 32'(busy), 32'd0);
        single_read("single_read", 32'h8002_0010, 32'hDEAD_BEEF);
        tick();
        check("dout_hold_idle", dout, 32'hDEAD_BEEF);

        // 16-beat write burst with a second burst queued back-to-back.
        busy_cnt = 0;
        enable = 1'b1; rw = 1'b1; addr = 32'h8002_0000; access_size = 2'b11; din = 32'd0;
        tick();
        enable = 1'b0;
        for (int k = 1; k < 16; k++) begin
            if (busy) busy_cnt++;
            din = 32'(k);
            if (k == 15) begin
                enable = 1'b1; addr = 32'h8002_0040; access_size = 2'b11; rw = 1'b1;
            end
            tick();
        end
        check("wr16_busy_cycles", 32'(busy_cnt), 32'd15);
        check("wr16_busy_end", 32'(busy), 32'd0);
        din = 32'd16;
        tick();
        enable = 1'b0;
        check("wr16_b2b_accept", 32'(busy), 32'd1);
        busy_cnt = 1;
        for (int k = 1; k < 16; k++) begin
            din = 32'(16 + k);
            tick();
            if (k < 15 && busy) busy_cnt++;
        end
        rw = 1'b0;
        check("wr16b_busy_cycles", 32'(busy_cnt), 32'd15);
        check("wr16b_busy_end", 32'(busy), 32'd0);

        fill_seq(32'd0);
        burst_read("rd16_lo", 32'h8002_0000, 2'b11, 1'b0);
        fill_seq(32'd16);
        burst_read("rd16_hi", 32'h8002_0040, 2'b11, 1'b0);

        // Burst read of 8 while the request inputs toggle.
        fill_seq(32'd0);
        burst_read("rd8_toggle", 32'h8002_0000, 2'b10, 1'b1);

        // Sizes 01 and 10 at other start addresses.
        fill_seq(32'd8);
        burst_read("rd4", 32'h8002_0020, 2'b01, 1'b0);
        fill_seq(32'd16);
        burst_read("rd8", 32'h8002_0040, 2'b10, 1'b0);

        // Out-of-range accesses leave memory untouched and read as zero.
        single_write(32'h8002_FFFC, 32'hCAFE_F00D);
        single_write(32'h8001_FFFC, 32'h1234_5678);
        single_read("rd_word1", 32'h8002_0004, 32'd1);
        single_read("rd_below_base", 32'h8001_FFFC, 32'h0);
        single_read("rd_last_word", 32'h8002_FFFC, 32'hCAFE_F00D);
        single_read("rd_after_word1", 32'h8002_0004, 32'd1);
        single_read("rd_above_top", 32'h8003_0000, 32'h0);
        fill_seq(32'd0);
        burst_read("rd4_base_intact", 32'h8002_0000, 2'b01, 1'b0);

        // Burst running off the top of the array: no wrap-around.
        vec[0] = 32'hC000_0000; vec[1] = 32'hC111_1111;
        vec[2] = 32'hC222_2222; vec[3] = 32'hC333_3333;
        burst_write("wr4_top", 32'h8002_FFF8, 2'b01);
        vec[2] = 32'h0; vec[3] = 32'h0;
        burst_read("rd4_top", 32'h8002_FFF8, 2'b01, 1'b0);
        fill_seq(32'd0);
        burst_read("rd4_no_wrap", 32'h8002_0000, 2'b01, 1'b0);

        // Asynchronous reset in the middle of a 16-beat read.
        enable = 1'b1; rw = 1'b0; addr = 32'h8002_0000; access_size = 2'b11;
        tick();
        enable = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        check("pre_reset_dout", dout, 32'd5);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_dout", dout, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_dout", dout, 32'h0);
        single_read("post_reset_read", 32'h8002_0004, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
